regfile_wb_ctrl: RTL

Write-port controller for the register file. After reset it runs a clear sequence that writes zero to every register, one address per cycle. It then shares the single write port between two writeback requesters, port A (ALU) and port B (memory load), using a valid/ready handshake. The block sits between the pipeline writeback stage and the register file write inputs and is the only driver of those inputs.

---
 rtl/regfile_wb_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: register-file write-port controller with post-reset clear and two-requester arbitration
// Ports: CLK/reset (sync, active high); a_*/b_* valid-ready writeback requesters;
// write_en/write_reg_addr/write_reg_data registered register-file write port; busy high during clear.
// Optional macro REGFILE_WB_RR_EN selects round-robin on contention (default: A has fixed priority).
module regfile_wb_ctrl #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [W-1:0]  a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [W-1:0]  b_data,
    output logic          write_en,
    output logic [AW-1:0] write_reg_addr,
    output logic [W-1:0]  write_reg_data,
    output logic          busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic          b_wins;
    logic [AW-1:0] sel_addr;
    logic [W-1:0]  sel_data;
`ifdef REGFILE_WB_RR_EN
    // ptr set means B is favoured on the next contended cycle
    logic ptr;
    assign b_wins = !a_valid || ptr;
    always_ff @(posedge CLK) begin
        if (reset)
            ptr <= 1'b0;
        else if (state == RUN && a_valid && b_valid)
            ptr <= !ptr;
    end
`else
    assign b_wins = !a_valid;
`endif
    always_comb begin
        state_nx = (state == CLEAR && cnt == '1) ? RUN : state;
        busy     = (state == CLEAR);
        // grants are void while reset is asserted
        a_ready  = !reset && state == RUN && a_valid && !(b_valid && b_wins);
        b_ready  = !reset && state == RUN && b_valid && b_wins;
        sel_addr = a_ready ? a_addr : b_addr;
        sel_data = a_ready ? a_data : b_data;
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= CLEAR;
            cnt            <= '0;
            write_en       <= 1'b0;
            write_reg_addr <= '0;
            write_reg_data <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) begin
                write_en       <= 1'b1;
                write_reg_addr <= cnt;
                write_reg_data <= '0;
                cnt            <= cnt + 1'b1;
            end else if ((a_ready || b_ready) && sel_addr != '0) begin
                write_en       <= 1'b1;
                write_reg_addr <= sel_addr;
                write_reg_data <= sel_data;
            end else begin
                // idle or register-0 transfer: no write, address/data hold
                write_en <= 1'b0;
            end
        end
    end
endmodule
